// File: rtl/dac_frame_builder.sv
// -----------------------------------------------------------------------------
// dac_frame_builder
//
// Feeds the MCP4725 I2C write engine. A programmable sample-rate ticker
// launches one frame per tick. Each frame carries one 12-bit DAC code,
// generated as a constant, sawtooth, triangle or square waveform, and is
// packed as a 3-byte MCP4725 fast-write frame:
//   byte 0 : {DAC_ADDR, 1'b0}            (address + write)
//   byte 1 : {2'b00, PD_BITS, D11..D8}
//   byte 2 : D7..D0
// The bytes leave on a valid/ready stream. A tick that arrives while a frame
// is still in flight is discarded (dropped).
//
// Parameters
//   DAC_ADDR      7-bit I2C slave address
//   PD_BITS       power-down field, byte 1 bits [5:4]
//
// Ports
//   i_clk          system clock
//   reset_n        asynchronous active-low reset
//   i_enable       runs the sample-rate ticker
//   i_mode         0 constant, 1 sawtooth, 2 triangle, 3 square
//   i_step         per-tick increment for sawtooth / triangle
//   i_const        code used in constant mode
//   i_rate         tick period minus one, in i_clk cycles
//   o_byte         current frame byte
//   o_byte_valid   o_byte is valid
//   i_byte_ready   downstream accepts the byte (transfer = valid && ready)
//   o_frame_start  high while byte 0 is presented
//   o_frame_last   high while byte 2 is presented
//   o_sample       sample latched into the current/last frame
//   o_drop_count   saturating count of ticks dropped while busy
//
// Build option
//   DAC_FRAME_DROPCNT_EN  when defined, the drop counter is built; otherwise
//                         o_drop_count is tied to 8'h00. Dropped ticks are
//                         discarded the same way in both builds.
//
// FSM states
//   state   | meaning
//   IDLE    | no frame in flight, waiting for a tick
//   ADDR    | presenting byte 0 (address + W)
//   HI      | presenting byte 1 (PD bits + D11..D8)
//   LO      | presenting byte 2 (D7..D0)
// -----------------------------------------------------------------------------
module dac_frame_builder #(
  parameter logic [6:0] DAC_ADDR = 7'h61,
  parameter logic [1:0] PD_BITS  = 2'b00
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic [11:0] i_step,
  input  logic [11:0] i_const,
  input  logic [15:0] i_rate,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_frame_start,
  output logic        o_frame_last,
  output logic [11:0] o_sample,
  output logic [7:0]  o_drop_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_SAW   = 2'd1;
  localparam logic [1:0] MODE_TRI   = 2'd2;

  state_t      state;
  logic [15:0] rate_cnt;
  logic        tick;
  logic        dir_down;
  logic [11:0] next_sample;
  logic        next_dir_down;
  logic [12:0] sum_up;

  // ---------------------------------------------------------------------------
  // Sample-rate ticker. i_rate is compared live, so a rate change takes effect
  // on the running count. The tick is a decode of the registered count and is
  // consumed by the FSM on the same edge that wraps the counter.
  // ---------------------------------------------------------------------------
  assign tick = i_enable && (rate_cnt == i_rate);

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_cnt <= 16'd0;
    end else if (!i_enable) begin
      rate_cnt <= 16'd0;
    end else if (tick) begin
      rate_cnt <= 16'd0;
    end else begin
      rate_cnt <= rate_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-sample generator. It is evaluated every cycle but committed only when
  // a frame launches, so mode/step changes apply at the next launching tick.
  // The triangle compare is done on 13 bits so an overshoot past 4095 clamps
  // instead of wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_sample   = o_sample;
    next_dir_down = dir_down;
    sum_up        = {1'b0, o_sample} + {1'b0, i_step};
    case (i_mode)
      MODE_CONST: begin
        next_sample = i_const;
      end
      MODE_SAW: begin
        next_sample = sum_up[11:0];
      end
      MODE_TRI: begin
        if (!dir_down) begin
          if (sum_up >= 13'd4095) begin
            next_sample   = 12'hFFF;
            next_dir_down = 1'b1;
          end else begin
            next_sample = sum_up[11:0];
          end
        end else begin
          if (o_sample <= i_step) begin
            next_sample   = 12'h000;
            next_dir_down = 1'b0;
          end else begin
            next_sample = o_sample - i_step;
          end
        end
      end
      default: begin
        next_sample = (o_sample == 12'h000) ? 12'hFFF : 12'h000;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. All stream outputs are registered and only change on a
  // transfer, so they hold stable while the downstream stalls and there is no
  // combinational path from i_byte_ready to any output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      o_byte        <= 8'h00;
      o_byte_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_last  <= 1'b0;
      o_sample      <= 12'h000;
      dir_down      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state         <= ST_ADDR;
            o_sample      <= next_sample;
            dir_down      <= next_dir_down;
            o_byte        <= {DAC_ADDR, 1'b0};
            o_byte_valid  <= 1'b1;
            o_frame_start <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (i_byte_ready) begin
            state         <= ST_HI;
            o_byte        <= {2'b00, PD_BITS, o_sample[11:8]};
            o_frame_start <= 1'b0;
          end
        end
        ST_HI: begin
          if (i_byte_ready) begin
            state        <= ST_LO;
            o_byte       <= o_sample[7:0];
            o_frame_last <= 1'b1;
          end
        end
        ST_LO: begin
          if (i_byte_ready) begin
            state        <= ST_IDLE;
            o_byte       <= 8'h00;
            o_byte_valid <= 1'b0;
            o_frame_last <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter. Any tick seen outside IDLE is lost, including one that lands
  // on the same edge as the LO transfer, because the FSM is still in LO then.
  // ---------------------------------------------------------------------------
`ifdef DAC_FRAME_DROPCNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= 8'h00;
    end else if (tick && (state != ST_IDLE) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end

  assign o_drop_count = drop_cnt;
`else
  assign o_drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_dac_frame_builder.sv
module tb_dac_frame_builder;

  localparam logic [6:0] ADDR = 7'h61;
  localparam logic [1:0] PD   = 2'b00;

  typedef struct packed {
    logic [7:0]  b;
    logic        s;
    logic        l;
    logic [11:0] smp;
  } item_t;

  logic        i_clk;
  logic        reset_n;
  logic        i_enable;
  logic [1:0]  i_mode;
  logic [11:0] i_step;
  logic [11:0] i_const;
  logic [15:0] i_rate;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_frame_start;
  logic        o_frame_last;
  logic [11:0] o_sample;
  logic [7:0]  o_drop_count;

  item_t       sb[$];
  logic [11:0] tbl [8];
  int          compared;
  int          mismatched;

  dac_frame_builder #(.DAC_ADDR(ADDR), .PD_BITS(PD)) dut (
    .i_clk         (i_clk),
    .reset_n       (reset_n),
    .i_enable      (i_enable),
    .i_mode        (i_mode),
    .i_step        (i_step),
    .i_const       (i_const),
    .i_rate        (i_rate),
    .o_byte        (o_byte),
    .o_byte_valid  (o_byte_valid),
    .i_byte_ready  (i_byte_ready),
    .o_frame_start (o_frame_start),
    .o_frame_last  (o_frame_last),
    .o_sample      (o_sample),
    .o_drop_count  (o_drop_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task push_frame(input logic [11:0] s);
    sb.push_back({{ADDR, 1'b0}, 1'b1, 1'b0, s});
    sb.push_back({{2'b00, PD, s[11:8]}, 1'b0, 1'b0, s});
    sb.push_back({s[7:0], 1'b0, 1'b1, s});
  endtask

  task do_reset();
    i_enable = 1'b0;
    @(negedge i_clk);
    reset_n = 1'b0;
    @(negedge i_clk);
    reset_n = 1'b1;
    sb.delete();
  endtask

  // Power-on state, then an asynchronous reset landing while HI is presented.
  task test_reset();
    int cyc;
    int seen_valid;
    compared++;
    if ({o_byte_valid, o_byte, o_frame_start, o_frame_last, o_sample, o_drop_count} !== 31'h0) begin
      mismatched++;
      $display("FAIL por_state got v=%b b=%h s=%b l=%b smp=%h d=%h required all zero",
               o_byte_valid, o_byte, o_frame_start, o_frame_last, o_sample, o_drop_count);
    end
    i_mode = 2'd0; i_const = 12'h123; i_rate = 16'd3; i_byte_ready = 1'b0;
    i_enable = 1'b1;
    cyc = 0;
    while (!o_byte_valid && cyc < 50) begin
      @(negedge i_clk); cyc++;
    end
    compared++;
    if (o_byte !== 8'hC2 || o_frame_start !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_addr_byte got b=%h s=%b required b=c2 s=1", o_byte, o_frame_start);
    end
    i_byte_ready = 1'b1;
    @(negedge i_clk);
    i_byte_ready = 1'b0;
    compared++;
    if (o_byte !== 8'h01 || o_byte_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_hi_byte got b=%h v=%b required b=01 v=1", o_byte, o_byte_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    compared++;
    if ({o_byte_valid, o_byte, o_frame_start, o_frame_last, o_sample, o_drop_count} !== 31'h0) begin
      mismatched++;
      $display("FAIL async_reset got v=%b b=%h s=%b l=%b smp=%h d=%h required all zero",
               o_byte_valid, o_byte, o_frame_start, o_frame_last, o_sample, o_drop_count);
    end
    i_enable = 1'b0;
    i_byte_ready = 1'b1;
    @(negedge i_clk);
    reset_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_byte_valid) seen_valid++;
    end
    compared++;
    if (seen_valid !== 0) begin
      mismatched++;
      $display("FAIL post_reset_quiet got %0d valid cycles required 0", seen_valid);
    end
  endtask

  // Runs n frames and scoreboards every byte, flag and latched sample, plus
  // frame cadence and the drop counter at every frame start.
  task test_stream(input string name, input logic [1:0] mode, input logic [11:0] step,
                   input logic [11:0] cval, input logic [15:0] rate, input int n);
    item_t e;
    int cyc, nf, last_start, budget, period, exp_d;
    do_reset();
    i_mode = mode; i_step = step; i_const = cval; i_rate = rate; i_byte_ready = 1'b1;
    for (int k = 0; k < n; k++) push_frame((mode == 2'd0) ? cval : tbl[k]);
    period = (rate == 16'd1) ? 4 : int'(rate) + 1;
    budget = n * period + 60;
    nf = 0; cyc = 0; last_start = -1;
    i_enable = 1'b1;
    while ((sb.size() > 0 || o_byte_valid) && cyc < budget) begin
      @(negedge i_clk); cyc++;
      if (o_byte_valid && i_byte_ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL %s extra_byte got %h required none", name, o_byte);
        end else begin
          e = sb.pop_front();
          if ({o_byte, o_frame_start, o_frame_last, o_sample} !== e) begin
            mismatched++;
            $display("FAIL %s byte got b=%h s=%b l=%b smp=%h required b=%h s=%b l=%b smp=%h",
                     name, o_byte, o_frame_start, o_frame_last, o_sample, e.b, e.s, e.l, e.smp);
          end
        end
        if (o_frame_start) begin
          nf++;
          if (last_start >= 0) begin
            compared++;
            if (cyc - last_start !== period) begin
              mismatched++;
              $display("FAIL %s cadence got %0d cycles required %0d", name, cyc - last_start, period);
            end
          end
          last_start = cyc;
`ifdef DAC_FRAME_DROPCNT_EN
          exp_d = (rate == 16'd1) ? ((nf - 1 > 255) ? 255 : nf - 1) : 0;
`else
          exp_d = 0;
`endif
          compared++;
          if (o_drop_count !== 8'(exp_d)) begin
            mismatched++;
            $display("FAIL %s drop_count frame %0d got %0d required %0d", name, nf, o_drop_count, exp_d);
          end
          if (nf == n) i_enable = 1'b0;
        end
      end
    end
    compared++;
    if (sb.size() != 0 || cyc >= budget) begin
      mismatched++;
      $display("FAIL %s timeout got %0d bytes pending required 0", name, sb.size());
    end
  endtask

  // Downstream stalls for 5 cycles while HI is presented.
  task test_stall();
    item_t e;
    int cyc;
    do_reset();
    i_mode = 2'd0; i_const = 12'hA5C; i_rate = 16'd20; i_byte_ready = 1'b1;
    push_frame(12'hA5C);
    i_enable = 1'b1;
    cyc = 0;
    while (!o_byte_valid && cyc < 60) begin
      @(negedge i_clk); cyc++;
    end
    i_enable = 1'b0;
    compared++;
    e = sb.pop_front();
    if ({o_byte, o_frame_start, o_frame_last, o_sample} !== e) begin
      mismatched++;
      $display("FAIL stall_addr got b=%h s=%b required b=%h s=%b", o_byte, o_frame_start, e.b, e.s);
    end
    @(negedge i_clk);
    i_byte_ready = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      compared++;
      if (o_byte_valid !== 1'b1 || {o_byte, o_frame_start, o_frame_last, o_sample} !== e) begin
        mismatched++;
        $display("FAIL stall_hold cycle %0d got v=%b b=%h required v=1 b=%h", i, o_byte_valid, o_byte, e.b);
      end
    end
    i_byte_ready = 1'b1;
    @(negedge i_clk);
    e = sb.pop_front();
    compared++;
    if (o_byte_valid !== 1'b1 || {o_byte, o_frame_start, o_frame_last, o_sample} !== e) begin
      mismatched++;
      $display("FAIL stall_resume got v=%b b=%h l=%b required v=1 b=%h l=%b",
               o_byte_valid, o_byte, o_frame_last, e.b, e.l);
    end
    @(negedge i_clk);
    compared++;
    if (o_byte_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_end got v=%b required 0", o_byte_valid);
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    reset_n = 1'b0; i_enable = 1'b0; i_mode = 2'd0; i_step = 12'h000;
    i_const = 12'h000; i_rate = 16'd0; i_byte_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    reset_n = 1'b1;
    @(negedge i_clk);

    test_reset();

    test_stream("constant", 2'd0, 12'h000, 12'h7FF, 16'd9, 3);

    tbl[0] = 12'h400; tbl[1] = 12'h800; tbl[2] = 12'hC00; tbl[3] = 12'h000;
    tbl[4] = 12'h400;
    test_stream("sawtooth", 2'd1, 12'h400, 12'h000, 16'd5, 5);

    tbl[0] = 12'h600; tbl[1] = 12'hC00; tbl[2] = 12'hFFF; tbl[3] = 12'h9FF;
    tbl[4] = 12'h3FF; tbl[5] = 12'h000; tbl[6] = 12'h600;
    test_stream("triangle", 2'd2, 12'h600, 12'h000, 16'd5, 7);

    tbl[0] = 12'hFFF; tbl[1] = 12'h000; tbl[2] = 12'hFFF; tbl[3] = 12'h000;
    test_stream("square", 2'd3, 12'h000, 12'h000, 16'd3, 4);

    test_stream("drop_rate1", 2'd0, 12'h000, 12'h055, 16'd1, 300);

    test_stall();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
